i2c_temp_sensor_slave: RTL and testbench

I2C_TEMP_SENSOR_SLAVE -- requirements
Module: i2c_temp_sensor_slave

---
 rtl/i2c_temp_sensor_slave_pkg.sv | 35 +++
 rtl/i2c_bus_sync.sv | 34 +++
 rtl/i2c_temp_sensor_slave.sv | 200 ++++++++++++++++++++
 tb/tb_i2c_temp_sensor_slave.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_temp_sensor_slave_pkg.sv
// Shared definitions for the I2C temperature-sensor slave: state encoding,
// register pointer indices, address default and register reset values.
package i2c_temp_sensor_slave_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned CNT_W  = 4;

  localparam logic [CNT_W-1:0]  BIT_LAST        = 4'd8;
  localparam logic [6:0]        DEV_ADD_DEFAULT = 7'h48;
  localparam logic [WORD_W-1:0] CONFIG_RST      = 16'h0000;
  localparam logic [WORD_W-1:0] TLOW_RST        = 16'h4B00;
  localparam logic [WORD_W-1:0] THIGH_RST       = 16'h5000;

  typedef enum logic [1:0] {
    PTR_TEMP   = 2'd0,
    PTR_CONFIG = 2'd1,
    PTR_TLOW   = 2'd2,
    PTR_THIGH  = 2'd3
  } ptr_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_WAIT_STOP
  } state_e;

endpackage

// File: rtl/i2c_bus_sync.sv
// Double-flop synchronisers for SCL/SDA plus SCL edge and START/STOP detection.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_s_o,
  output logic scl_rise_c,
  output logic scl_fall_c,
  output logic start_c,
  output logic stop_c
);

  // [1] is the synchronised value, [2] its previous sample for edge detection
  logic [2:0] scl_q;
  logic [2:0] sda_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_q <= '1;
      sda_q <= '1;
    end else begin
      scl_q <= {scl_q[1:0], scl_i};
      sda_q <= {sda_q[1:0], sda_i};
    end
  end

  assign sda_s_o    = sda_q[1];
  assign scl_rise_c = scl_q[1] & ~scl_q[2];
  assign scl_fall_c = ~scl_q[1] & scl_q[2];
  assign start_c    = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
  assign stop_c     = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];

endmodule

// File: rtl/i2c_temp_sensor_slave.sv
// I2C slave exposing a live temperature word plus CONFIG/TLOW/THIGH registers
// and a hysteretic thermostat alert.
module i2c_temp_sensor_slave
  import i2c_temp_sensor_slave_pkg::*;
#(
  parameter logic [6:0] DEV_ADD = DEV_ADD_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scl,
  inout  wire               sda,
  input  logic [WORD_W-1:0] temp_in,
  output logic              alert,
  output logic              busy
);

  logic sda_s, scl_rise_c, scl_fall_c, start_c, stop_c;

  i2c_bus_sync u_sync (
    .clk        (clk),
    .rst_n      (reset),
    .scl_i      (scl),
    .sda_i      (sda),
    .sda_s_o    (sda_s),
    .scl_rise_c (scl_rise_c),
    .scl_fall_c (scl_fall_c),
    .start_c    (start_c),
    .stop_c     (stop_c)
  );

  state_e             state_q;
  logic [CNT_W-1:0]   bit_cnt_q;
  logic [BYTE_W-1:0]  shreg_q;
  logic [BYTE_W-1:0]  wr_msb_q;
  logic [WORD_W-1:0]  snap_q;
  logic [WORD_W-1:0]  config_q;
  logic [WORD_W-1:0]  tlow_q;
  logic [WORD_W-1:0]  thigh_q;
  ptr_e               ptr_q;
  logic               byte_sel_q;
  logic               rw_q;
  logic               mst_nack_q;
  logic               sda_oe_q;
  logic               busy_q;
  logic               alert_q;

  logic [WORD_W-1:0]  rd_word_c;
  logic [BYTE_W-1:0]  cur_byte_c;
  logic               next_bit_c;

  // Open-drain: only ever pull low; reset clears the enable asynchronously
  assign sda   = sda_oe_q ? 1'b0 : 1'bz;
  assign busy  = busy_q;
  assign alert = alert_q;

  always_comb begin
    rd_word_c = temp_in;
    case (ptr_q)
      PTR_CONFIG: rd_word_c = config_q;
      PTR_TLOW:   rd_word_c = tlow_q;
      PTR_THIGH:  rd_word_c = thigh_q;
      default:    rd_word_c = temp_in;
    endcase
  end

  assign cur_byte_c = byte_sel_q ? snap_q[BYTE_W-1:0] : snap_q[WORD_W-1:BYTE_W];
  assign next_bit_c = cur_byte_c[3'(4'd7 - bit_cnt_q)];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      wr_msb_q   <= '0;
      snap_q     <= '0;
      config_q   <= CONFIG_RST;
      tlow_q     <= TLOW_RST;
      thigh_q    <= THIGH_RST;
      ptr_q      <= PTR_TEMP;
      byte_sel_q <= 1'b0;
      rw_q       <= 1'b0;
      mst_nack_q <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else if (start_c) begin
      state_q    <= ST_ADDR;
      bit_cnt_q  <= '0;
      byte_sel_q <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b1;
    end else if (stop_c) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else if (scl_rise_c) begin
      case (state_q)
        ST_ADDR, ST_PTR, ST_WR_DATA, ST_RD_DATA: begin
          shreg_q   <= {shreg_q[BYTE_W-2:0], sda_s};
          bit_cnt_q <= bit_cnt_q + 4'd1;
        end
        ST_RD_ACK: mst_nack_q <= sda_s;
        default: ;
      endcase
    end else if (scl_fall_c) begin
      // All sda drive changes happen here, just after SCL falls
      case (state_q)
        ST_ADDR: if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_q <= '0;
          if (shreg_q[7:1] == DEV_ADD) begin
            state_q  <= ST_ADDR_ACK;
            rw_q     <= shreg_q[0];
            sda_oe_q <= 1'b1;
          end else begin
            state_q <= ST_WAIT_STOP;
          end
        end
        ST_ADDR_ACK: begin
          bit_cnt_q <= '0;
          if (rw_q) begin
            state_q    <= ST_RD_DATA;
            snap_q     <= rd_word_c;
            byte_sel_q <= 1'b0;
            sda_oe_q   <= ~rd_word_c[WORD_W-1];
          end else begin
            state_q  <= ST_PTR;
            sda_oe_q <= 1'b0;
          end
        end
        ST_PTR: if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_q <= '0;
          if (shreg_q[7:2] == 6'd0) begin
            ptr_q    <= ptr_e'(shreg_q[1:0]);
            state_q  <= ST_PTR_ACK;
            sda_oe_q <= 1'b1;
          end else begin
            state_q <= ST_WAIT_STOP;
          end
        end
        ST_PTR_ACK: begin
          state_q    <= ST_WR_DATA;
          byte_sel_q <= 1'b0;
          sda_oe_q   <= 1'b0;
        end
        ST_WR_DATA: if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_q <= '0;
          state_q   <= ST_WR_ACK;
          sda_oe_q  <= 1'b1;
          if (!byte_sel_q) begin
            wr_msb_q <= shreg_q;
          end else begin
            case (ptr_q)
              PTR_CONFIG: config_q <= {wr_msb_q, shreg_q};
              PTR_TLOW:   tlow_q   <= {wr_msb_q, shreg_q};
              PTR_THIGH:  thigh_q  <= {wr_msb_q, shreg_q};
              default: ;
            endcase
          end
        end
        ST_WR_ACK: begin
          state_q    <= ST_WR_DATA;
          byte_sel_q <= ~byte_sel_q;
          sda_oe_q   <= 1'b0;
        end
        ST_RD_DATA: begin
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_q <= '0;
            state_q   <= ST_RD_ACK;
            sda_oe_q  <= 1'b0;
          end else begin
            sda_oe_q <= ~next_bit_c;
          end
        end
        ST_RD_ACK: begin
          if (mst_nack_q) begin
            state_q  <= ST_WAIT_STOP;
            sda_oe_q <= 1'b0;
          end else begin
            state_q    <= ST_RD_DATA;
            byte_sel_q <= ~byte_sel_q;
            sda_oe_q   <= ~(byte_sel_q ? snap_q[WORD_W-1] : snap_q[BYTE_W-1]);
          end
        end
        default: ;
      endcase
    end
  end

  // Thermostat with hysteresis; set dominates when the thresholds are inverted
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alert_q <= 1'b0;
    end else if ($signed(temp_in) >= $signed(thigh_q)) begin
      alert_q <= 1'b1;
    end else if ($signed(temp_in) < $signed(tlow_q)) begin
      alert_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2c_temp_sensor_slave.sv
// Directed bench: bit-banged I2C master against i2c_temp_sensor_slave.
module tb_i2c_temp_sensor_slave;

  localparam int unsigned Q = 5;

  logic        clk;
  logic        reset;
  logic        scl;
  logic        sda_pull;
  logic [15:0] temp_in;
  logic        alert;
  logic        busy;
  wire         sda;

  int unsigned n_checks;
  int unsigned n_pass;

  assign sda = sda_pull ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_temp_sensor_slave #(.DEV_ADD(7'h48)) dut (
    .clk     (clk),
    .reset   (reset),
    .scl     (scl),
    .sda     (sda),
    .temp_in (temp_in),
    .alert   (alert),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic do_start();
    wait_q(); sda_pull = 1'b0;
    wait_q(); scl = 1'b1;
    wait_q(); sda_pull = 1'b1;
    wait_q(); scl = 1'b0;
  endtask

  // Ends exactly at the STOP edge (sda released while scl high)
  task automatic do_stop();
    wait_q(); sda_pull = 1'b1;
    wait_q(); scl = 1'b1;
    wait_q(); sda_pull = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      wait_q(); sda_pull = ~b[i];
      wait_q(); scl = 1'b1;
      wait_q();
      wait_q(); scl = 1'b0;
    end
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    send_bits(b);
    wait_q(); sda_pull = 1'b0;
    wait_q(); scl = 1'b1;
    wait_q(); ack = sda;
    wait_q(); scl = 1'b0;
  endtask

  task automatic read_byte(input logic mst_ack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      wait_q(); sda_pull = 1'b0;
      wait_q(); scl = 1'b1;
      wait_q(); b[i] = sda;
      wait_q(); scl = 1'b0;
    end
    wait_q(); sda_pull = ~mst_ack;
    wait_q(); scl = 1'b1;
    wait_q();
    wait_q(); scl = 1'b0;
  endtask

  // START (or repeated START), 0x91, read MSB with ACK, LSB with NACK, STOP
  task automatic read_cur(input string tag, output logic [15:0] w);
    logic a;
    logic [7:0] hi, lo;
    do_start();
    write_byte(8'h91, a); chk({tag, " rd addr ack"}, 16'(a), 16'h0);
    read_byte(1'b0, hi);
    read_byte(1'b1, lo);
    wait_q(); chk({tag, " sda released after nack"}, 16'(sda), 16'h1);
    do_stop();
    w = {hi, lo};
  endtask

  task automatic read_reg(input string tag, input logic [7:0] p, output logic [15:0] w);
    logic a;
    do_start();
    write_byte(8'h90, a); chk({tag, " wr addr ack"}, 16'(a), 16'h0);
    write_byte(p, a);     chk({tag, " ptr ack"}, 16'(a), 16'h0);
    read_cur(tag, w);
  endtask

  task automatic write_reg(input string tag, input logic [7:0] p, input logic [15:0] w);
    logic a;
    do_start();
    write_byte(8'h90, a);   chk({tag, " addr ack"}, 16'(a), 16'h0);
    write_byte(p, a);       chk({tag, " ptr ack"}, 16'(a), 16'h0);
    write_byte(w[15:8], a); chk({tag, " msb ack"}, 16'(a), 16'h0);
    write_byte(w[7:0], a);  chk({tag, " lsb ack"}, 16'(a), 16'h0);
    do_stop();
  endtask

  task automatic set_temp(input logic [15:0] t);
    temp_in = t;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic        a;
    logic [15:0] w;
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b0;
    scl      = 1'b1;
    sda_pull = 1'b0;
    temp_in  = 16'h0000;
    repeat (5) @(negedge clk);
    chk("reset busy", 16'(busy), 16'h0);
    chk("reset alert", 16'(alert), 16'h0);
    chk("reset sda", 16'(sda), 16'h1);
    reset = 1'b1;
    wait_q();

    // Write THIGH = 0x5500 and time the busy release
    do_start();
    repeat (4) @(negedge clk);
    chk("busy after start", 16'(busy), 16'h1);
    write_byte(8'h90, a); chk("w31 addr ack", 16'(a), 16'h0);
    write_byte(8'h03, a); chk("w31 ptr ack", 16'(a), 16'h0);
    write_byte(8'h55, a); chk("w31 msb ack", 16'(a), 16'h0);
    write_byte(8'h00, a); chk("w31 lsb ack", 16'(a), 16'h0);
    do_stop();
    chk("busy at stop edge", 16'(busy), 16'h1);
    repeat (3) @(negedge clk);
    chk("busy 3 cycles after stop", 16'(busy), 16'h0);
    read_reg("rb thigh", 8'h03, w);
    chk("thigh readback", w, 16'h5500);

    // Temperature read via repeated START
    temp_in = 16'h1980;
    read_reg("temp", 8'h00, w);
    chk("temp msb byte", 16'(w[15:8]), 16'h0019);
    chk("temp lsb byte", 16'(w[7:0]), 16'h0080);

    // Foreign address: no ACK, bus untouched, registers unchanged
    do_start();
    write_byte(8'hA0, a); chk("foreign addr nack", 16'(a), 16'h1);
    write_byte(8'h03, a); chk("foreign byte1 nack", 16'(a), 16'h1);
    write_byte(8'h12, a); chk("foreign byte2 nack", 16'(a), 16'h1);
    write_byte(8'h34, a); chk("foreign byte3 nack", 16'(a), 16'h1);
    do_stop();
    read_cur("ptr kept", w);
    chk("ptr persists temp", w, 16'h1980);
    read_reg("rb thigh2", 8'h03, w);
    chk("thigh unchanged", w, 16'h5500);
    read_reg("rb config", 8'h01, w);
    chk("config reset value", w, 16'h0000);

    // Out-of-range pointer is refused and the old pointer survives
    read_reg("rb tlow", 8'h02, w);
    chk("tlow reset value", w, 16'h4B00);
    do_start();
    write_byte(8'h90, a); chk("bad ptr addr ack", 16'(a), 16'h0);
    write_byte(8'h07, a); chk("bad ptr nack", 16'(a), 16'h1);
    do_stop();
    read_cur("after bad ptr", w);
    chk("ptr unchanged read", w, 16'h4B00);

    // Write to temperature pointer is acked and discarded
    write_reg("w temp", 8'h00, 16'hABCD);
    temp_in = 16'h0123;
    read_cur("temp after wr", w);
    chk("temp write discarded", w, 16'h0123);

    // Consecutive pairs overwrite the same register
    do_start();
    write_byte(8'h90, a); chk("pair addr ack", 16'(a), 16'h0);
    write_byte(8'h01, a); chk("pair ptr ack", 16'(a), 16'h0);
    write_byte(8'h11, a); chk("pair1 msb ack", 16'(a), 16'h0);
    write_byte(8'h22, a); chk("pair1 lsb ack", 16'(a), 16'h0);
    write_byte(8'h33, a); chk("pair2 msb ack", 16'(a), 16'h0);
    write_byte(8'h44, a); chk("pair2 lsb ack", 16'(a), 16'h0);
    do_stop();
    read_cur("config rb", w);
    chk("config last pair", w, 16'h3344);

    // Alert hysteresis with THIGH = 0x5000, TLOW = 0x4B00
    write_reg("w thigh", 8'h03, 16'h5000);
    set_temp(16'h4A00); chk("alert 4A00", 16'(alert), 16'h0);
    set_temp(16'h5000); chk("alert 5000", 16'(alert), 16'h1);
    set_temp(16'h4C00); chk("alert 4C00 held", 16'(alert), 16'h1);
    set_temp(16'h4AFF); chk("alert 4AFF", 16'(alert), 16'h0);

    // Inverted thresholds: set wins; negative temperature compares signed
    write_reg("w thigh low", 8'h03, 16'h4000);
    set_temp(16'h4500); chk("alert set wins", 16'(alert), 16'h1);
    set_temp(16'hFF00); chk("alert negative temp", 16'(alert), 16'h0);

    // Reset during the MSB ACK of a TLOW write
    do_start();
    write_byte(8'h90, a); chk("rst addr ack", 16'(a), 16'h0);
    write_byte(8'h02, a); chk("rst ptr ack", 16'(a), 16'h0);
    send_bits(8'h12);
    wait_q(); sda_pull = 1'b0;
    wait_q(); scl = 1'b1;
    wait_q(); chk("msb ack driven", 16'(sda), 16'h0);
    reset = 1'b0;
    #1;
    chk("sda released on reset", 16'(sda), 16'h1);
    chk("busy low on reset", 16'(busy), 16'h0);
    wait_q(); scl = 1'b0;
    wait_q(); scl = 1'b1;
    wait_q(); reset = 1'b1;
    wait_q();
    read_reg("after reset", 8'h02, w);
    chk("tlow not committed", w, 16'h4B00);
    read_reg("thigh after reset", 8'h03, w);
    chk("thigh reset value", w, 16'h5000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
